// File: rtl/seq_divider_sel.sv
// seq_divider_sel
// ---------------
// Multi-cycle unsigned divider with operand-pair selection. On an accepted
// start, channel `select` becomes the dividend and channel (select+1) mod
// NUM_IN the divisor. A restoring datapath then retires one quotient bit per
// cycle, MSB first. A zero divisor skips the datapath and reports an error.
//
// Optional feature macro: SEL_DIV_REM_EN (adds the `remainder` output).
//
// Handshake: `start` is sampled only while idle (busy=0). When a division is
// accepted, busy rises and stays high until the edge that ends the one-cycle
// `done` pulse. quotient/error/remainder update only on entry to DONE and
// hold until the next DONE. There is no queuing: a start seen while busy is
// dropped.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      division request (sampled in IDLE)
//   select     operand pair index, sampled with start
//   data_in    NUM_IN packed channels, channel i at [i*WIDTH +: WIDTH]
//   busy       high whenever the FSM is not idle
//   done       one-cycle result-valid pulse
//   quotient   result quotient (all ones on divide-by-zero)
//   error      last division had a zero divisor
//   remainder  result remainder (only with SEL_DIV_REM_EN)

module seq_divider_sel #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        quotient,
    output logic                    error
`ifdef SEL_DIV_REM_EN
    ,
    output logic [WIDTH-1:0]        remainder
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    // dvd starts as the dividend and shifts left each iteration; quotient
    // bits enter at the LSB, so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] prem;
    logic [CNT_W-1:0] cnt;

    logic [SEL_W-1:0] dvs_idx;
    logic [WIDTH-1:0] dvd_sel;
    logic [WIDTH-1:0] dvs_sel;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // Divisor index wraps naturally because NUM_IN is a power of two.
    assign dvs_idx = select + SEL_W'(1);
    assign dvd_sel = data_in[select*WIDTH +: WIDTH];
    assign dvs_sel = data_in[dvs_idx*WIDTH +: WIDTH];

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits
    // because it can momentarily reach 2*divisor-1.
    assign shifted  = {prem, dvd[WIDTH-1]};
    assign ge       = shifted >= {1'b0, dvs};
    assign prem_nxt = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    assign quo_nxt  = {dvd[WIDTH-2:0], ge};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            prem      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            error     <= 1'b0;
`ifdef SEL_DIV_REM_EN
            remainder <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd  <= dvd_sel;
                        dvs  <= dvs_sel;
                        prem <= '0;
                        cnt  <= '0;
                        if (dvs_sel == '0) begin
                            // Divide-by-zero result is published right away.
                            state     <= DONE;
                            quotient  <= '1;
                            error     <= 1'b1;
`ifdef SEL_DIV_REM_EN
                            remainder <= dvd_sel;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd  <= quo_nxt;
                    prem <= prem_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        quotient  <= quo_nxt;
                        error     <= 1'b0;
`ifdef SEL_DIV_REM_EN
                        remainder <= prem_nxt;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
